// File: rtl/motor_run_ctrl.sv
// Run/pause/brake sequencer with a seconds countdown for the DC motor H-bridge.
// Optional MOTOR_RUN_CTRL_BCD_EN adds a registered two-digit BCD copy of remain_sec.
module motor_run_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_SEC  = 99,
    parameter int DEAD_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_run,
    input  logic [1:0] motor_direction,
    output logic       o_run,
    output logic [3:0] o_state,
    output logic [1:0] in1_in2,
    output logic [6:0] remain_sec,
`ifdef MOTOR_RUN_CTRL_BCD_EN
    output logic [7:0] remain_bcd,
`endif
    output logic       done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [6:0]    SEC_MAX   = 7'(MAX_SEC);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SET   = 4'd1,
        S_RUN   = 4'd2,
        S_PAUSE = 4'd3,
        S_BRAKE = 4'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [DW-1:0]   dead_q, dead_d;
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      pend_q, pend_d;   // direction requested while braking
    logic [6:0]      remain_d;
    logic            done_d;
    logic [1:0]      drive_d;
    logic            run_d;
    logic            tick_wrap;

    assign o_state   = state_q;
    assign tick_wrap = (tick_q == TICK_LAST);

    // NOTE: synchronous reset, so it lives inside the clocked branch and not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            dead_q     <= '0;
            dir_q      <= 2'b00;
            pend_q     <= 2'b00;
            remain_sec <= '0;
            done       <= 1'b0;
            in1_in2    <= 2'b00;
            o_run      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            dead_q     <= dead_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            remain_sec <= remain_d;
            done       <= done_d;
            in1_in2    <= drive_d;
            o_run      <= run_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        dead_d   = dead_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        remain_d = remain_sec;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_set) begin
                    state_d  = S_SET;
                    remain_d = '0;
                end
            end
            S_SET: begin
                if (btn_set) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                end else if (btn_run) begin
                    if (remain_sec != '0) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                        dir_d   = motor_direction;
                    end
                end else if (btn_up && remain_sec < SEC_MAX) begin
                    remain_d = remain_sec + 7'd1;
                end
            end
            S_RUN, S_BRAKE: begin
                if (btn_set) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                    tick_d   = '0;
                end else if (btn_run) begin
                    state_d = S_PAUSE;
                end else begin
                    tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                    if (tick_wrap && remain_sec <= 7'd1) begin
                        // Expiry wins over any pending direction work.
                        state_d  = S_IDLE;
                        remain_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        if (tick_wrap)
                            remain_d = remain_sec - 7'd1;
                        if (state_q == S_RUN) begin
                            if (motor_direction != dir_q) begin
                                state_d = S_BRAKE;
                                dead_d  = '0;
                                pend_d  = motor_direction;
                            end
                        end else if (motor_direction != pend_q) begin
                            dead_d = '0;
                            pend_d = motor_direction;
                        end else if (dead_q == DEAD_LAST) begin
                            state_d = S_RUN;
                            dir_d   = motor_direction;
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (btn_set) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                    tick_d   = '0;
                end else if (btn_run) begin
                    state_d = S_RUN;
                    dir_d   = motor_direction;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive pins are decoded from the next state so they register alongside it.
    always_comb begin
        drive_d = 2'b00;
        run_d   = 1'b0;
        case (state_d)
            S_RUN: begin
                run_d = 1'b1;
                case (dir_d)
                    2'b01:   drive_d = 2'b10;
                    2'b10:   drive_d = 2'b01;
                    default: drive_d = 2'b00;
                endcase
            end
            S_BRAKE: begin
                run_d   = 1'b1;
                drive_d = 2'b11;
            end
            default: ;
        endcase
    end

`ifdef MOTOR_RUN_CTRL_BCD_EN
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v % 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset)
            remain_bcd <= 8'h00;
        else
            remain_bcd <= to_bcd(remain_d);
    end
`endif

endmodule

// File: tb/tb_motor_run_ctrl.sv
// Bench for motor_run_ctrl: directed vector table, corner sequences and a random run
// against a model that tracks remaining time in clock cycles.
module tb_motor_run_ctrl;

    localparam int TICK_DIV = 100;
    localparam int MAX_SEC  = 99;
    localparam int DEAD_CYC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_run = 1'b0;
    logic [1:0] motor_direction = 2'b00;
    logic       o_run;
    logic [3:0] o_state;
    logic [1:0] in1_in2;
    logic [6:0] remain_sec;
    logic       done;
`ifdef MOTOR_RUN_CTRL_BCD_EN
    logic [7:0] remain_bcd;
`endif

    motor_run_ctrl #(
        .TICK_DIV(TICK_DIV),
        .MAX_SEC (MAX_SEC),
        .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_set        (btn_set),
        .btn_up         (btn_up),
        .btn_run        (btn_run),
        .motor_direction(motor_direction),
        .o_run          (o_run),
        .o_state        (o_state),
        .in1_in2        (in1_in2),
        .remain_sec     (remain_sec),
`ifdef MOTOR_RUN_CTRL_BCD_EN
        .remain_bcd     (remain_bcd),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: time left is kept in clock cycles, display is its ceiling in seconds.
    typedef enum int {M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_BRAKE = 4} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_left = 0;
    int         m_brake = 0;
    logic [1:0] m_dir = 2'b00;
    logic [1:0] m_pend = 2'b00;
    bit         m_done = 1'b0;
    logic [1:0] cur_dir = 2'b00;

    task automatic model_step(input bit rst_n, input bit set, input bit up, input bit run,
                              input logic [1:0] dir);
        m_done = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_left = 0; m_dir = 2'b00; m_pend = 2'b00;
            return;
        end
        case (m_mode)
            M_IDLE: if (set) begin m_mode = M_SET; m_left = 0; end
            M_SET: begin
                if (set) begin
                    m_mode = M_IDLE; m_left = 0;
                end else if (run) begin
                    if (m_left > 0) begin m_mode = M_RUN; m_dir = dir; end
                end else if (up) begin
                    m_left = (m_left + TICK_DIV > MAX_SEC * TICK_DIV) ? MAX_SEC * TICK_DIV
                                                                      : m_left + TICK_DIV;
                end
            end
            M_RUN, M_BRAKE: begin
                if (set) begin
                    m_mode = M_IDLE; m_left = 0;
                end else if (run) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_IDLE; m_done = 1'b1;
                    end else if (m_mode == M_RUN) begin
                        if (dir != m_dir) begin
                            m_mode = M_BRAKE; m_brake = DEAD_CYC; m_pend = dir;
                        end
                    end else if (dir != m_pend) begin
                        m_brake = DEAD_CYC; m_pend = dir;
                    end else begin
                        m_brake--;
                        if (m_brake == 0) begin m_mode = M_RUN; m_dir = dir; end
                    end
                end
            end
            M_PAUSE: begin
                if (set) begin
                    m_mode = M_IDLE; m_left = 0;
                end else if (run) begin
                    m_mode = M_RUN; m_dir = dir;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [14:0] model_outputs();
        logic [1:0] drv;
        logic [6:0] rem;
        drv = 2'b00;
        if (m_mode == M_BRAKE) drv = 2'b11;
        else if (m_mode == M_RUN && m_dir == 2'b01) drv = 2'b10;
        else if (m_mode == M_RUN && m_dir == 2'b10) drv = 2'b01;
        rem = 7'((m_left + TICK_DIV - 1) / TICK_DIV);
        return {4'(m_mode), (m_mode == M_RUN || m_mode == M_BRAKE), drv, rem, m_done};
    endfunction

    task automatic compare_model();
        check("model", {o_state, o_run, in1_in2, remain_sec, done}, model_outputs());
`ifdef MOTOR_RUN_CTRL_BCD_EN
        begin
            int r;
            r = (m_left + TICK_DIV - 1) / TICK_DIV;
            check("model_bcd", remain_bcd, {4'(r / 10), 4'(r % 10)});
        end
`endif
    endtask

    task automatic step(input bit rst_n, input bit set, input bit up, input bit run,
                        input logic [1:0] dir);
        reset = rst_n; btn_set = set; btn_up = up; btn_run = run; motor_direction = dir;
        @(posedge clk);
        #1;
        model_step(rst_n, set, up, run, dir);
        btn_set = 1'b0; btn_up = 1'b0; btn_run = 1'b0; reset = 1'b1;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, cur_dir);
    endtask

    task automatic start_run(input int secs, input logic [1:0] dir);
        cur_dir = dir;
        step(1'b1, 1'b1, 1'b0, 1'b0, cur_dir);
        for (int i = 0; i < secs; i++) step(1'b1, 1'b0, 1'b1, 1'b0, cur_dir);
        step(1'b1, 1'b0, 1'b0, 1'b1, cur_dir);
    endtask

    // Steps until done is seen (bounded) and checks how many edges it took.
    task automatic wait_done(input string name, input int expected, input int limit);
        int n;
        n = 0;
        while (n < limit) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, cur_dir);
            n++;
            if (done === 1'b1) break;
        end
        check(name, n, expected);
    endtask

    typedef struct {
        bit         set, up, run;
        logic [1:0] dir;
        logic [3:0] st;
        bit         orun;
        logic [1:0] drv;
        logic [6:0] rem;
        bit         dn;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1, 0, 0, 2'b01, 4'd1, 0, 2'b00, 7'd0, 0};
        vecs[1] = '{0, 1, 0, 2'b01, 4'd1, 0, 2'b00, 7'd1, 0};
        vecs[2] = '{0, 1, 0, 2'b01, 4'd1, 0, 2'b00, 7'd2, 0};
        vecs[3] = '{0, 1, 0, 2'b01, 4'd1, 0, 2'b00, 7'd3, 0};
        vecs[4] = '{0, 0, 1, 2'b01, 4'd2, 1, 2'b10, 7'd3, 0};

        // Reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("reset", {o_state, o_run, in1_in2, remain_sec, done}, 15'd0);

        // Set 3 s and run forward
        for (int i = 0; i < 5; i++) begin
            cur_dir = vecs[i].dir;
            step(1'b1, vecs[i].set, vecs[i].up, vecs[i].run, vecs[i].dir);
            check($sformatf("vec%0d", i), {o_state, o_run, in1_in2, remain_sec, done},
                  {vecs[i].st, vecs[i].orun, vecs[i].drv, vecs[i].rem, vecs[i].dn});
        end
        idle(299);
        check("expire_pre", {o_state, remain_sec, done}, {4'd2, 7'd1, 1'b0});
        idle(1);
        check("expire", {o_state, in1_in2, remain_sec, done}, {4'd0, 2'b00, 7'd0, 1'b1});
        idle(1);
        check("done_one_cycle", done, 1'b0);

        // btn_run with zero time stays in SET; btn_up saturates
        step(1'b1, 1'b1, 1'b0, 1'b0, cur_dir);
        step(1'b1, 1'b0, 1'b0, 1'b1, cur_dir);
        check("run_zero_ignored", {o_state, remain_sec}, {4'd1, 7'd0});
        for (int i = 0; i < 105; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, cur_dir);
`ifdef MOTOR_RUN_CTRL_BCD_EN
            if (i == 46) check("bcd47", remain_bcd, 8'h47);
`endif
        end
        check("saturate", remain_sec, 7'd99);
        step(1'b1, 1'b1, 1'b0, 1'b0, cur_dir);
        check("set_exit", {o_state, remain_sec}, {4'd0, 7'd0});

        // Direction change across a second boundary
        start_run(3, 2'b01);
        idle(97);
        cur_dir = 2'b10;
        step(1'b1, 1'b0, 1'b0, 1'b0, cur_dir);
        check("brake_enter", {o_state, o_run, in1_in2, remain_sec}, {4'd4, 1'b1, 2'b11, 7'd3});
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, cur_dir);
            check($sformatf("brake_hold%0d", i), {o_state, in1_in2}, {4'd4, 2'b11});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, cur_dir);
        check("brake_exit", {o_state, in1_in2, remain_sec}, {4'd2, 2'b01, 7'd2});
        wait_done("brake_expiry_cycles", 198, 400);

        // Pause holds time; expiry 200 - 37 edges after resume
        start_run(2, 2'b01);
        idle(37);
        step(1'b1, 1'b0, 1'b0, 1'b1, cur_dir);
        check("pause_enter", {o_state, o_run, in1_in2, remain_sec}, {4'd3, 1'b0, 2'b00, 7'd2});
        idle(500);
        check("pause_hold", {o_state, remain_sec}, {4'd3, 7'd2});
        step(1'b1, 1'b0, 1'b0, 1'b1, cur_dir);
        check("resume", {o_state, in1_in2}, {4'd2, 2'b10});
        wait_done("pause_expiry_cycles", 163, 400);

        // set beats run; reset mid-run
        start_run(3, 2'b10);
        idle(20);
        step(1'b1, 1'b1, 1'b0, 1'b1, cur_dir);
        check("set_over_run", {o_state, in1_in2, remain_sec, done}, {4'd0, 2'b00, 7'd0, 1'b0});
        start_run(3, 2'b10);
        idle(20);
        step(1'b0, 1'b0, 1'b0, 1'b0, cur_dir);
        check("reset_mid_run", {o_state, o_run, in1_in2, remain_sec, done}, 15'd0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int  r;
            bit  s, u, rn, rs;
            bit  busy;
            busy = (m_mode == M_RUN || m_mode == M_BRAKE);
            r  = busy ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 99));
            s  = busy ? (r < 2) : (r < 4);
            rn = busy ? (r >= 2 && r < 5) : (r >= 4 && r < 12);
            u  = busy ? (r >= 5 && r < 40) : (r >= 12 && r < 40);
            rs = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 79) == 0) cur_dir = 2'($urandom_range(0, 3));
            step(!rs, s, u, rn, cur_dir);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_run_ctrl.md
Name: motor_run_ctrl

Overview:
Sequencing controller for the DC motor H-bridge path. Takes single-cycle debounced button pulses and the direction switches, manages a seconds countdown, and drives in1_in2. Inserts a brake interval on any direction change while running. Sits between the button debouncers and the H-bridge pins. remain_sec feeds the FND display driver.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s countdown tick (set small in simulation)
MAX_SEC, 99, saturation limit for the set time in seconds
DEAD_CYC, 1_000_000, clk cycles in BRAKE on a direction change (10 ms at 100 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
btn_set  input  1  1-cycle pulse, enter/leave set mode (BTNC)
btn_up  input  1  1-cycle pulse, +1 s in SET (BTNU)
btn_run  input  1  1-cycle pulse, run/pause toggle (BTND)
motor_direction  input  2  01 = forward, 10 = reverse, 00/11 = coast
o_run  output  1  high in RUN or BRAKE
o_state  output  4  0 IDLE, 1 SET, 2 RUN, 3 PAUSE, 4 BRAKE
in1_in2  output  2  H-bridge drive: 10 fwd, 01 rev, 00 coast, 11 brake
remain_sec  output  7  remaining/set seconds, 0..MAX_SEC
done  output  1  1-cycle pulse when the countdown expires

Behaviour:
- All outputs registered. Reset (reset==0 at a clk edge) -> IDLE, o_state=0, o_run=0, in1_in2=00, remain_sec=0, done=0, tick counter=0. This applies from any state, including mid-RUN.
- Button priority when pulses coincide: btn_set > btn_run > btn_up. Lower-priority pulses in that cycle are dropped.
- IDLE: in1_in2=00. btn_set -> SET with remain_sec=0.
- SET:
  - btn_up -> remain_sec+1, saturating at MAX_SEC.
  - btn_set -> IDLE, remain_sec cleared.
  - btn_run with remain_sec>0 -> RUN; the tick counter clears and motor_direction latches into dir_q.
  - btn_run with remain_sec==0 is ignored.
- RUN:
  - in1_in2 follows dir_q: 01->10, 10->01, 00/11->00.
  - The tick counter counts 0..TICK_DIV-1. On wrap, remain_sec decrements.
  - A decrement from 1 to 0 means: next state IDLE, in1_in2=00, done=1 for exactly that one cycle.
  - btn_run -> PAUSE; the tick counter and remain_sec are held.
  - btn_set -> IDLE; remain_sec cleared, no done.
  - motor_direction != dir_q -> BRAKE for DEAD_CYC cycles with in1_in2=11. dir_q reloads from motor_direction when BRAKE exits.
- BRAKE:
  - The countdown keeps running. Expiry inside BRAKE -> IDLE with done.
  - After DEAD_CYC cycles -> RUN with the new dir_q.
  - btn_run -> PAUSE; the dead-time counter is discarded.
  - Further direction changes restart the dead-time count.
- PAUSE: in1_in2=00, counters frozen.
  - btn_run -> RUN; motor_direction re-latches with no brake.
  - btn_set -> IDLE; remain_sec cleared.
- btn_up outside SET is ignored. done is never asserted except on countdown expiry.
- Widths: tick counter is $clog2(TICK_DIV) bits. Dead-time counter is $clog2(DEAD_CYC+1) bits. remain_sec never wraps below 0.

Optional Feature:
MOTOR_RUN_CTRL_BCD_EN:
- Defined: adds output remain_bcd[7:0], holding remain_sec as two BCD digits ([7:4] tens, [3:0] ones). It is registered in the same cycle as remain_sec, and its reset value is 8'h00.
- Undefined: the port and its logic are absent, and the FND driver performs its own conversion.

Test Plan (TICK_DIV=100, DEAD_CYC=4, MAX_SEC=99):
- Reset low 2 cycles, then btn_set, btn_up x3, btn_run with dir=01 -> o_state 0->1->2, remain_sec=3, in1_in2=10, o_run=1. After 300 cycles: remain_sec=0, done 1-cycle pulse, o_state=0, in1_in2=00.
- In SET, btn_up x105 -> remain_sec saturates at 99. btn_run with remain_sec=0 in a fresh SET -> stays in SET.
- RUN dir=01, switch dir to 10 -> in1_in2=11 for exactly 4 cycles, o_state=4, then 01, o_state=2. remain_sec continues decrementing across the brake.
- RUN at remain_sec=2, btn_run -> PAUSE, in1_in2=00, hold 500 cycles with remain_sec unchanged. btn_run -> RUN; expiry occurs exactly 200 minus the pre-pause tick count later.
- btn_set and btn_run in the same cycle during RUN -> IDLE, remain_sec=0, no done. reset low mid-RUN -> next edge all outputs at reset values.
- With MOTOR_RUN_CTRL_BCD_EN: remain_sec=47 -> remain_bcd=8'h47.
